// File: rtl/uart_txrx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_txrx : full-duplex 8N1 UART, shared prescaler, 16x RX oversampling    |
// | UART_RX_SYNC_EN : two-flop rxd synchroniser (undefined: single register)  |
// | Revision  : 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_txrx #(
  parameter int         data_bits                    = 8,
  parameter int         transmitted_bit_counter_bits = 4,
  parameter int         received_bit_counter_bits    = 3,
  parameter int         bit_cell_counter_bits        = 4,
  parameter logic [2:0] br                           = 3'b000
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [data_bits-1:0] DBUS,
  input  logic                 txd_startH,
  output logic                 txd,
  output logic                 txd_doneH,
  input  logic                 rxd,
  output logic [data_bits-1:0] RDR,
  output logic                 rxd_readyH
);

  localparam logic [6:0] c_tick_mask = 7'((1 << br) - 1);
  localparam logic [bit_cell_counter_bits-1:0] c_cell_last = '1;
  localparam logic [bit_cell_counter_bits-1:0] c_cell_mid  = c_cell_last >> 1;
  localparam logic [transmitted_bit_counter_bits-1:0] c_tx_last =
    transmitted_bit_counter_bits'(data_bits - 1);
  localparam logic [received_bit_counter_bits-1:0] c_rx_last =
    received_bit_counter_bits'(data_bits - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [6:0] presc_q;
  logic       w_tick;
  logic       w_rx;

  tx_state_t                                tx_state_q, tx_state_d;
  logic [bit_cell_counter_bits-1:0]         tx_cell_q, tx_cell_d;
  logic [transmitted_bit_counter_bits-1:0]  tx_bit_q, tx_bit_d;
  logic [data_bits-1:0]                     tx_sh_q, tx_sh_d;

  rx_state_t                                rx_state_q, rx_state_d;
  logic [bit_cell_counter_bits-1:0]         rx_cell_q, rx_cell_d;
  logic [received_bit_counter_bits-1:0]     rx_bit_q, rx_bit_d;
  logic [data_bits-1:0]                     rx_sh_q, rx_sh_d;
  logic [data_bits-1:0]                     rdr_q, rdr_d;
  logic                                     ready_q, ready_d;

  // With br = 0 the mask is empty, so the tick is permanently asserted.
  assign w_tick = ((presc_q & c_tick_mask) == c_tick_mask);

`ifdef UART_RX_SYNC_EN
  logic rx_meta_q, rx_sync_q;
  always_ff @(posedge sysclk) begin
    if (rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
    end
  end
  assign w_rx = rx_sync_q;
`else
  logic rx_reg_q;
  always_ff @(posedge sysclk) begin
    if (rst_n) rx_reg_q <= 1'b1;
    else       rx_reg_q <= rxd;
  end
  assign w_rx = rx_reg_q;
`endif

  always_ff @(posedge sysclk) begin
    if (rst_n) begin
      presc_q    <= '0;
      tx_state_q <= TX_IDLE;
      tx_cell_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      rx_state_q <= RX_IDLE;
      rx_cell_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rdr_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      presc_q    <= presc_q + 7'd1;
      tx_state_q <= tx_state_d;
      tx_cell_q  <= tx_cell_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_cell_q  <= rx_cell_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rdr_q      <= rdr_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cell_d  = tx_cell_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_doneH  = 1'b0;
    txd        = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (txd_startH) begin
          tx_sh_d    = DBUS;
          tx_cell_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        txd = 1'b0;
        if (w_tick) begin
          if (tx_cell_q == c_cell_last) begin
            tx_cell_d  = '0;
            tx_state_d = TX_DATA;
          end else begin
            tx_cell_d = tx_cell_q + 1'b1;
          end
        end
      end
      TX_DATA: begin
        txd = tx_sh_q[0];
        if (w_tick) begin
          if (tx_cell_q == c_cell_last) begin
            tx_cell_d = '0;
            tx_sh_d   = tx_sh_q >> 1;
            if (tx_bit_q == c_tx_last) begin
              tx_bit_d   = '0;
              tx_state_d = TX_STOP;
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
            end
          end else begin
            tx_cell_d = tx_cell_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (tx_cell_q == c_cell_last) begin
            txd_doneH = 1'b1;
            tx_cell_d = '0;
            // A held request chains straight into the next start bit.
            if (txd_startH) begin
              tx_sh_d    = DBUS;
              tx_state_d = TX_START;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_cell_d = tx_cell_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cell_d  = rx_cell_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rdr_d      = rdr_q;
    ready_d    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!w_rx) begin
          rx_cell_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (rx_cell_q == c_cell_mid) begin
            rx_cell_d  = '0;
            rx_state_d = w_rx ? RX_IDLE : RX_DATA;
          end else begin
            rx_cell_d = rx_cell_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (rx_cell_q == c_cell_last) begin
            rx_cell_d = '0;
            rx_sh_d   = {w_rx, rx_sh_q[data_bits-1:1]};
            if (rx_bit_q == c_rx_last) begin
              rx_bit_d   = '0;
              rx_state_d = RX_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end else begin
            rx_cell_d = rx_cell_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (rx_cell_q == c_cell_last) begin
            rx_cell_d = '0;
            if (w_rx) begin
              rdr_d      = rx_sh_q;
              ready_d    = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              rx_state_d = RX_WAIT_HIGH;
            end
          end else begin
            rx_cell_d = rx_cell_q + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (w_rx) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign RDR        = rdr_q;
  assign rxd_readyH = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_txrx.sv
`default_nettype none
// Self-checking bench for uart_txrx: loopback and hand-driven rxd frames, br = 000.
module tb_uart_txrx;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [7:0] DBUS;
  logic       txd_startH;
  logic       txd;
  logic       txd_doneH;
  logic       rxd;
  logic [7:0] RDR;
  logic       rxd_readyH;

  logic       loop_en;
  logic       rxd_man;
  logic       txd_d1;
  logic [7:0] last_good;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_txrx dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .DBUS       (DBUS),
    .txd_startH (txd_startH),
    .txd        (txd),
    .txd_doneH  (txd_doneH),
    .rxd        (rxd),
    .RDR        (RDR),
    .rxd_readyH (rxd_readyH)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) txd_d1 <= txd;
  assign rxd = loop_en ? txd_d1 : rxd_man;

  always @(negedge sysclk) begin
    if (rxd_readyH === 1'b1) got_q.push_back(RDR);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_lvl);
    for (int idx = 0; idx < 10; idx++) begin
      rxd_man = (idx == 9) ? stop_lvl : frame_bit(b, idx);
      repeat (16) @(negedge sysclk);
    end
    rxd_man = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge sysclk);
      total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
      total++; if (RDR !== 8'h00) begin bad++; $display("FAIL reset_rdr: got %h want 00", RDR); end
      total++; if (txd_doneH !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", txd_doneH); end
      total++; if (rxd_readyH !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", rxd_readyH); end
    end
    rst_n = 1'b0;
  endtask

  task automatic test_single;
    logic [7:0] g, e;
    loop_en = 1'b1;
    DBUS = 8'hBD;
    txd_startH = 1'b1;
    exp_q.push_back(8'hBD);
    for (int i = 0; i < 160; i++) begin
      @(negedge sysclk);
      if (i == 0) txd_startH = 1'b0;
      total++;
      if (txd !== frame_bit(8'hBD, i / 16)) begin
        bad++; $display("FAIL single_txd[%0d]: got %b want %b", i, txd, frame_bit(8'hBD, i / 16));
      end
      total++;
      if (txd_doneH !== (i == 159)) begin
        bad++; $display("FAIL single_done[%0d]: got %b want %b", i, txd_doneH, (i == 159));
      end
    end
    for (int k = 0; k < 200 && got_q.size() == 0; k++) @(negedge sysclk);
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL single_ready_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL single_rdr: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    last_good = 8'hBD;
    repeat (20) @(negedge sysclk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] g, e;
    int n;
    DBUS = 8'hBD;
    txd_startH = 1'b1;
    repeat (3) exp_q.push_back(8'hBD);
    for (int i = 0; i < 480; i++) begin
      @(negedge sysclk);
      total++;
      if (txd !== frame_bit(8'hBD, (i % 160) / 16)) begin
        bad++; $display("FAIL b2b_txd[%0d]: got %b want %b", i, txd, frame_bit(8'hBD, (i % 160) / 16));
      end
      total++;
      if (txd_doneH !== ((i % 160) == 159)) begin
        bad++; $display("FAIL b2b_done[%0d]: got %b want %b", i, txd_doneH, ((i % 160) == 159));
      end
      if (i == 479) txd_startH = 1'b0;
    end
    @(negedge sysclk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL b2b_idle_txd: got %b want 1", txd); end
    for (int k = 0; k < 200 && got_q.size() < 3; k++) @(negedge sysclk);
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL b2b_ready_count: got %0d want 3", got_q.size()); end
    n = got_q.size();
    for (int j = 0; j < n && exp_q.size() > 0; j++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL b2b_rdr[%0d]: got %h want %h", j, g, e); end
    end
    got_q.delete(); exp_q.delete();
    repeat (20) @(negedge sysclk);
  endtask

  task automatic test_false_start;
    logic [7:0] g, e;
    loop_en = 1'b0;
    rxd_man = 1'b1;
    repeat (4) @(negedge sysclk);
    rxd_man = 1'b0;
    repeat (4) @(negedge sysclk);
    rxd_man = 1'b1;
    repeat (40) @(negedge sysclk);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL false_start_ready: got %0d pulses want 0", got_q.size()); end
    total++; if (RDR !== last_good) begin bad++; $display("FAIL false_start_rdr: got %h want %h", RDR, last_good); end
    got_q.delete();
    exp_q.push_back(8'hA5);
    send_rx_frame(8'hA5, 1'b1);
    for (int k = 0; k < 100 && got_q.size() == 0; k++) @(negedge sysclk);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL false_start_recover_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL false_start_recover_rdr: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    last_good = 8'hA5;
    repeat (20) @(negedge sysclk);
  endtask

  task automatic test_framing;
    logic [7:0] g, e;
    send_rx_frame(8'h55, 1'b0);
    repeat (30) @(negedge sysclk);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL framing_ready: got %0d pulses want 0", got_q.size()); end
    total++; if (RDR !== last_good) begin bad++; $display("FAIL framing_rdr: got %h want %h", RDR, last_good); end
    got_q.delete();
    exp_q.push_back(8'h3C);
    send_rx_frame(8'h3C, 1'b1);
    for (int k = 0; k < 100 && got_q.size() == 0; k++) @(negedge sysclk);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL framing_next_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL framing_next_rdr: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    last_good = 8'h3C;
    repeat (20) @(negedge sysclk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] g, e;
    loop_en = 1'b1;
    repeat (4) @(negedge sysclk);
    DBUS = 8'h96;
    txd_startH = 1'b1;
    for (int i = 0; i <= 70; i++) begin
      @(negedge sysclk);
      if (i == 0) txd_startH = 1'b0;
    end
    total++; if (txd !== frame_bit(8'h96, 4)) begin bad++; $display("FAIL midrst_bit4: got %b want %b", txd, frame_bit(8'h96, 4)); end
    rst_n = 1'b1;
    @(negedge sysclk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL midrst_txd: got %b want 1", txd); end
    total++; if (txd_doneH !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", txd_doneH); end
    total++; if (rxd_readyH !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", rxd_readyH); end
    total++; if (RDR !== 8'h00) begin bad++; $display("FAIL midrst_rdr: got %h want 00", RDR); end
    @(negedge sysclk);
    rst_n = 1'b0;
    repeat (20) @(negedge sysclk);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL midrst_stray_ready: got %0d want 0", got_q.size()); end
    got_q.delete();
    DBUS = 8'hC3;
    txd_startH = 1'b1;
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 160; i++) begin
      @(negedge sysclk);
      if (i == 0) txd_startH = 1'b0;
      total++;
      if (txd !== frame_bit(8'hC3, i / 16)) begin
        bad++; $display("FAIL midrst_fresh_txd[%0d]: got %b want %b", i, txd, frame_bit(8'hC3, i / 16));
      end
    end
    for (int k = 0; k < 200 && got_q.size() == 0; k++) @(negedge sysclk);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL midrst_fresh_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL midrst_fresh_rdr: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n      = 1'b1;
    DBUS       = 8'h00;
    txd_startH = 1'b0;
    loop_en    = 1'b0;
    rxd_man    = 1'b1;
    last_good  = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_false_start;
    test_framing;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
